// File: rtl/hazard_control_unit.sv
// hazard_control_unit: load-use stall, branch flush and memory-busy freeze
// control for a classic five-stage pipeline. Control outputs are
// combinational so a hazard stalls in the cycle it is presented; only the
// stall-cycle statistic is registered.
//
// state      | meaning
// -----------+----------------------------------------------------------
// RUN        | normal flow; a load-use hazard stalls here for one cycle
// LOAD_STALL | extra load-latency bubbles; cnt holds the remaining count
module hazard_control_unit #(
  parameter int REG_ADDR_W      = 5,
  parameter int LOAD_LATENCY    = 1,
  parameter int ZERO_REG_IGNORE = 1,
  parameter int CNT_W           = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ID_EX_memRead,
  input  logic [REG_ADDR_W-1:0] ID_EX_rt,
  input  logic [REG_ADDR_W-1:0] IF_ID_rs,
  input  logic [REG_ADDR_W-1:0] IF_ID_rt,
  input  logic                  IF_ID_rs_used,
  input  logic                  IF_ID_rt_used,
  input  logic                  branch_taken,
  input  logic                  mem_busy,
  input  logic                  stat_clear,
  output logic                  PCWrite,
  output logic                  IF_IDWrite,
  output logic                  ID_EXWrite,
  output logic                  EX_MEMWrite,
  output logic                  memRegWriteSelection,
  output logic                  IF_IDFlush,
  output logic                  ID_EXFlush,
  output logic                  stall_active,
  output logic [CNT_W-1:0]      stall_cycles
);

  typedef enum logic {RUN, LOAD_STALL} state_t;

  // The first hazard cycle is spent in RUN, so LOAD_STALL covers the rest.
  localparam logic [3:0] STALL_INIT = 4'(LOAD_LATENCY - 1);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       rs_match, rt_match, rt_is_zero, hazard;

  assign rs_match   = IF_ID_rs_used && (IF_ID_rs == ID_EX_rt);
  assign rt_match   = IF_ID_rt_used && (IF_ID_rt == ID_EX_rt);
  assign rt_is_zero = (ZERO_REG_IGNORE != 0) && (ID_EX_rt == '0);
  assign hazard     = ID_EX_memRead && (rs_match || rt_match) && !rt_is_zero;

  // State and remaining-cycle register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= RUN;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Prioritised next-state and control decode: reset, freeze, flush, stall.
  always_comb begin
    state_nxt            = state;
    cnt_nxt              = cnt;
    PCWrite              = 1'b1;
    IF_IDWrite           = 1'b1;
    ID_EXWrite           = 1'b1;
    EX_MEMWrite          = 1'b1;
    memRegWriteSelection = 1'b0;
    IF_IDFlush           = 1'b0;
    ID_EXFlush           = 1'b0;
    if (!rst_n) begin
      state_nxt = RUN;
      cnt_nxt   = 4'd0;
    end else if (mem_busy) begin
      // Frozen stages keep their contents, so branch/hazard are seen later.
      PCWrite     = 1'b0;
      IF_IDWrite  = 1'b0;
      ID_EXWrite  = 1'b0;
      EX_MEMWrite = 1'b0;
    end else if (branch_taken) begin
      IF_IDFlush = 1'b1;
      ID_EXFlush = 1'b1;
      state_nxt  = RUN;
      cnt_nxt    = 4'd0;
    end else if (state == LOAD_STALL) begin
      // ID/EX holds a bubble now, so its memRead is not looked at.
      PCWrite              = 1'b0;
      IF_IDWrite           = 1'b0;
      memRegWriteSelection = 1'b1;
      cnt_nxt              = cnt - 4'd1;
      if (cnt == 4'd1) state_nxt = RUN;
    end else if (hazard) begin
      PCWrite              = 1'b0;
      IF_IDWrite           = 1'b0;
      memRegWriteSelection = 1'b1;
      if (LOAD_LATENCY > 1) begin
        state_nxt = LOAD_STALL;
        cnt_nxt   = STALL_INIT;
      end
    end
  end

  assign stall_active = ~PCWrite;

  // Saturating count of cycles with the PC held; clear beats increment.
  always_ff @(posedge clk) begin
    if (!rst_n || stat_clear) begin
      stall_cycles <= '0;
    end else if (!PCWrite && (stall_cycles != {CNT_W{1'b1}})) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule
